mbist_march_fsm: RTL
====================

MBIST_MARCH_FSM -- requirements
Module: mbist_march_fsm

Interface
REQ-001 SHALL have parameter BIST_ADDR_WD, default 9: address width.
REQ-002 SHALL have parameter BIST_DATA_WD, default 32: data width, multiple of 8.
REQ-003 SHALL have parameter BIST_ADDR_START, default 9'h000: first tested address.
REQ-004 SHALL have parameter BIST_ADDR_END, default 9'h1F8: last tested address, greater than BIST_ADDR_START.
REQ-005 SHALL have parameter BIST_MAX_REPAIR, default 4: number of tolerated (repairable) errors.
REQ-006 SHALL have port clk, input, 1: BIST clock; one clock only.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port bist_run, input, 1: level request to start and keep running the test.
REQ-009 SHALL have port bist_rdata, input, BIST_DATA_WD: memory read data, valid one cycle after bist_rd.
REQ-010 SHALL have ports bist_en, bist_wr and bist_rd, each output, 1: memory takeover, write strobe and read strobe.
REQ-011 SHALL have port bist_addr, output, BIST_ADDR_WD: memory address.
REQ-012 SHALL have port bist_wdata, output, BIST_DATA_WD: memory write data.
REQ-013 SHALL have port bist_error, output, 1: one-cycle miscompare pulse.
REQ-014 SHALL have port bist_error_addr, output, BIST_ADDR_WD: failing address, valid with bist_error.
REQ-015 SHALL have port bist_done, output, 1: test completed.
REQ-016 SHALL have port bist_fail, output, 1: error count exceeded BIST_MAX_REPAIR.
REQ-017 SHALL have port bist_err_cnt, output, 4: saturating miscompare count.

Function
REQ-018 SHALL execute March C- as six elements, E0..E5: E0 up W0; E1 up R0W1; E2 up R1W0; E3 down R0W1; E4 down R1W0; E5 down R0.
REQ-019 SHALL use the FSM states IDLE, WR, RD, CMP and DONE.
REQ-020 SHALL move IDLE->WR on bist_run=1, clearing err_cnt, fail, done and the element counter, and loading the address with BIST_ADDR_START.
REQ-021 In WR (E0), SHALL assert bist_wr for one cycle per address: 1 cycle/word.
REQ-022 In RD, SHALL assert bist_rd; in CMP on the next cycle, SHALL compare bist_rdata with the expected word and, for E1-E4, assert bist_wr with the inverted pattern at the same address: 2 cycles/word.
REQ-023 SHALL have E5 use RD/CMP with no write in CMP.
REQ-024 SHALL, on a CMP miscompare, pulse bist_error with bist_error_addr equal to the current address in that same cycle.
REQ-025 SHALL, on a CMP miscompare, increment err_cnt with saturation at 15.
REQ-026 SHALL set bist_fail sticky once err_cnt exceeds BIST_MAX_REPAIR.
REQ-027 SHALL step the address up from START to END in ascending elements and down from END to START in descending elements.
REQ-028 SHALL, at the last address of an element, advance to the next element and load the element's start address; after the last word of E5, SHALL go to DONE.
REQ-029 SHALL set total test length to 11*N cycles from the first access, where N = END-START+1.
REQ-030 SHALL hold bist_en=1 in WR/RD/CMP and 0 in IDLE/DONE.
REQ-031 SHALL keep bist_wr and bist_rd mutually exclusive.
REQ-032 SHALL hold bist_done=1 in DONE and go DONE->IDLE when bist_run=0; done, fail and err_cnt SHALL persist until the next start.
REQ-033 SHALL abort to IDLE on bist_run=0 in WR/RD/CMP: bist_en=0 next cycle, bist_done stays 0, and no bist_error is issued for a pending read.
REQ-034 SHALL, if bist_run=1 is seen in DONE, require it to drop before a restart.

Reset
REQ-035 SHALL, on rst_n=0, asynchronously force state=IDLE and every output to 0: bist_en, bist_wr, bist_rd, bist_addr, bist_wdata, bist_error, bist_error_addr, bist_done, bist_fail, bist_err_cnt.
REQ-036 SHALL treat reset mid-test as an abort; no state is retained.

Configuration
REQ-037 SHALL, with MBIST_CHECKERBOARD_EN defined, use background "0" = {BIST_DATA_WD/2{2'b01}} XOR-ed with all-ones when addr[0]=1, and background "1" = its inverse.
REQ-038 SHALL, without MBIST_CHECKERBOARD_EN, use "0" = all-zeros and "1" = all-ones.

Structure
REQ-039 SHALL place the state enum, the element encoding (E0..E5), the per-element direction/read/write-value table and the err_cnt width constant in package mbist_pkg.
REQ-040 SHALL implement the up/down address counter with start/end detect as sub-module mbist_addr_gen.

Verification (BIST_ADDR_WD=4, START=0, END=3, N=4, MAX_REPAIR=1)
REQ-041 SHALL cover: fault-free memory model, bist_run=1 -> bist_done=1 after 44 access cycles, err_cnt=0, fail=0, 44 cycles of bist_en.
REQ-042 SHALL cover: stuck-at-0 bit 0 at addr 2 -> bist_error pulses with error_addr=2 in E2, E4 (expected 1 reads) and E1/E3 per pattern; err_cnt matches the count; fail=1.
REQ-043 SHALL cover: single miscompare injected once at addr 1 in E1 -> err_cnt=1, fail=0, done=1.
REQ-044 SHALL cover: bist_run dropped in cycle 10 -> bist_en=0 next cycle, done=0, no error; re-run completes in 44 cycles.
REQ-045 SHALL cover: rst_n pulsed mid-E3 -> all outputs 0 immediately, state IDLE.
REQ-046 SHALL cover: with MBIST_CHECKERBOARD_EN, E0 writes 0x55555555 to addr 0 and 0xAAAAAAAA to addr 1.

Source files
------------

// File: rtl/mbist_pkg.sv
// ============================================================================
//  Module      : mbist_pkg
//  Description : Shared types for the March C- memory BIST: FSM states,
//                element encoding and the per-element access table.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mbist_pkg;

    localparam int unsigned C_ERR_CNT_WD = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CMP  = 3'd3,
        DONE = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } elem_e;

    typedef struct packed {
        logic down;    // address walks END -> START
        logic rd_val;  // background expected on read
        logic wr_en;   // element writes after its read (or alone in E0)
        logic wr_val;  // background written
    } elem_cfg_t;

    function automatic elem_cfg_t elem_cfg(input elem_e e);
        elem_cfg_t c;
        c = '0;
        case (e)
            E0:      c = '{down: 1'b0, rd_val: 1'b0, wr_en: 1'b1, wr_val: 1'b0};
            E1:      c = '{down: 1'b0, rd_val: 1'b0, wr_en: 1'b1, wr_val: 1'b1};
            E2:      c = '{down: 1'b0, rd_val: 1'b1, wr_en: 1'b1, wr_val: 1'b0};
            E3:      c = '{down: 1'b1, rd_val: 1'b0, wr_en: 1'b1, wr_val: 1'b1};
            E4:      c = '{down: 1'b1, rd_val: 1'b1, wr_en: 1'b1, wr_val: 1'b0};
            E5:      c = '{down: 1'b1, rd_val: 1'b0, wr_en: 1'b0, wr_val: 1'b0};
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mbist_addr_gen.sv
// ============================================================================
//  Module      : mbist_addr_gen
//  Description : Up/down address counter with load-to-start and last-address
//                detect for the March element currently running.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mbist_addr_gen #(
    parameter int unsigned ADDR_WD    = 9,
    parameter int unsigned ADDR_START = 'h000,
    parameter int unsigned ADDR_END   = 'h1F8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               load_down_i,
    input  logic               step_i,
    input  logic               dir_down_i,
    output logic [ADDR_WD-1:0] addr_o,
    output logic               last_o
);

    localparam logic [ADDR_WD-1:0] C_START = ADDR_WD'(ADDR_START);
    localparam logic [ADDR_WD-1:0] C_END   = ADDR_WD'(ADDR_END);

    logic [ADDR_WD-1:0] addr_q;
    logic [ADDR_WD-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_down_i ? C_END : C_START;
        end else if (step_i) begin
            addr_d = dir_down_i ? (addr_q - 1'b1) : (addr_q + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = dir_down_i ? (addr_q == C_START) : (addr_q == C_END);

endmodule

`default_nettype wire

// File: rtl/mbist_march_fsm.sv
// ============================================================================
//  Module      : mbist_march_fsm
//  Description : March C- memory BIST controller (E0..E5) with error pulse,
//                saturating error count and repair-budget fail flag.
//                Define MBIST_CHECKERBOARD_EN for a checkerboard background.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mbist_march_fsm
    import mbist_pkg::*;
#(
    parameter int unsigned BIST_ADDR_WD    = 9,
    parameter int unsigned BIST_DATA_WD    = 32,
    parameter int unsigned BIST_ADDR_START = 'h000,
    parameter int unsigned BIST_ADDR_END   = 'h1F8,
    parameter int unsigned BIST_MAX_REPAIR = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bist_run,
    input  logic [BIST_DATA_WD-1:0] bist_rdata,
    output logic                    bist_en,
    output logic                    bist_wr,
    output logic                    bist_rd,
    output logic [BIST_ADDR_WD-1:0] bist_addr,
    output logic [BIST_DATA_WD-1:0] bist_wdata,
    output logic                    bist_error,
    output logic [BIST_ADDR_WD-1:0] bist_error_addr,
    output logic                    bist_done,
    output logic                    bist_fail,
    output logic [C_ERR_CNT_WD-1:0] bist_err_cnt
);

    state_e                  state_q, state_d;
    elem_e                   elem_q, elem_d;
    logic [C_ERR_CNT_WD-1:0] err_cnt_q, err_cnt_d;
    logic                    fail_q, fail_d;
    logic                    done_q, done_d;

    logic                    w_load;
    logic                    w_load_down;
    logic                    w_step;
    logic [BIST_ADDR_WD-1:0] w_addr;
    logic                    w_last;
    elem_cfg_t               w_cfg;
    elem_cfg_t               w_next_cfg;
    logic [BIST_DATA_WD-1:0] w_bg;
    logic [BIST_DATA_WD-1:0] w_exp;
    logic [BIST_DATA_WD-1:0] w_wpat;

    assign w_cfg      = elem_cfg(elem_q);
    assign w_next_cfg = elem_cfg(elem_e'(elem_q + 3'd1));

`ifdef MBIST_CHECKERBOARD_EN
    assign w_bg = {(BIST_DATA_WD/2){2'b01}} ^ {BIST_DATA_WD{w_addr[0]}};
`else
    assign w_bg = '0;
`endif

    assign w_exp  = w_cfg.rd_val ? ~w_bg : w_bg;
    assign w_wpat = w_cfg.wr_val ? ~w_bg : w_bg;

    mbist_addr_gen #(
        .ADDR_WD    (BIST_ADDR_WD),
        .ADDR_START (BIST_ADDR_START),
        .ADDR_END   (BIST_ADDR_END)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (w_load),
        .load_down_i (w_load_down),
        .step_i      (w_step),
        .dir_down_i  (w_cfg.down),
        .addr_o      (w_addr),
        .last_o      (w_last)
    );

    always_comb begin
        state_d         = state_q;
        elem_d          = elem_q;
        err_cnt_d       = err_cnt_q;
        fail_d          = fail_q;
        done_d          = done_q;
        w_load          = 1'b0;
        w_load_down     = 1'b0;
        w_step          = 1'b0;
        bist_en         = 1'b0;
        bist_wr         = 1'b0;
        bist_rd         = 1'b0;
        bist_wdata      = '0;
        bist_error      = 1'b0;
        bist_error_addr = '0;

        case (state_q)
            IDLE: begin
                if (bist_run) begin
                    state_d   = WR;
                    elem_d    = E0;
                    err_cnt_d = '0;
                    fail_d    = 1'b0;
                    done_d    = 1'b0;
                    w_load    = 1'b1;
                end
            end
            WR: begin
                bist_en = 1'b1;
                if (!bist_run) begin
                    state_d = IDLE;
                end else begin
                    bist_wr    = 1'b1;
                    bist_wdata = w_wpat;
                    if (w_last) begin
                        elem_d      = E1;
                        w_load      = 1'b1;
                        w_load_down = w_next_cfg.down;
                        state_d     = RD;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            RD: begin
                bist_en = 1'b1;
                if (!bist_run) begin
                    state_d = IDLE;
                end else begin
                    bist_rd = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                bist_en = 1'b1;
                // An abort in this cycle drops the compare of the pending read.
                if (!bist_run) begin
                    state_d = IDLE;
                end else begin
                    if (bist_rdata != w_exp) begin
                        bist_error      = 1'b1;
                        bist_error_addr = w_addr;
                        err_cnt_d       = (err_cnt_q == {C_ERR_CNT_WD{1'b1}}) ?
                                          err_cnt_q : (err_cnt_q + 1'b1);
                        fail_d          = fail_q | (32'(err_cnt_d) > BIST_MAX_REPAIR);
                    end
                    if (w_cfg.wr_en) begin
                        bist_wr    = 1'b1;
                        bist_wdata = w_wpat;
                    end
                    state_d = RD;
                    if (!w_last) begin
                        w_step = 1'b1;
                    end else if (elem_q == E5) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        elem_d      = elem_e'(elem_q + 3'd1);
                        w_load      = 1'b1;
                        w_load_down = w_next_cfg.down;
                    end
                end
            end
            DONE: begin
                if (!bist_run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            elem_q    <= E0;
            err_cnt_q <= '0;
            fail_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            elem_q    <= elem_d;
            err_cnt_q <= err_cnt_d;
            fail_q    <= fail_d;
            done_q    <= done_d;
        end
    end

    assign bist_addr    = w_addr;
    assign bist_done    = done_q;
    assign bist_fail    = fail_q;
    assign bist_err_cnt = err_cnt_q;

endmodule

`default_nettype wire
